// File: rtl/game_mbox_pkg.sv
// Shared types and constants for the game/processor register-file mailbox.
package game_mbox_pkg;

   localparam int unsigned WORD_W = 32;

   localparam logic [4:0] MBOX_EVT_REG   = 5'd20;
   localparam logic [4:0] MBOX_REPLY_REG = 5'd21;
   localparam logic [4:0] MBOX_SHAPE_REG = 5'd25;
   localparam logic [4:0] MBOX_POINT_REG = 5'd26;

   typedef enum logic [1:0] {
      IDLE,
      INJECT,
      WAIT
   } mbox_state_e;

   // Writes to r0 are discarded by the register file, so such a cycle is free to steal.
   function automatic logic port_free(input logic we, input logic [4:0] wr_reg);
      return !we || (wr_reg == 5'd0);
   endfunction

endpackage

// File: rtl/mbox_fifo.sv
// Small synchronous event FIFO; full/empty are derived from registered pointers only.
module mbox_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             ctrl_reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic             do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = mem[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/game_mailbox_ctrl.sv
// Injects buffered game events into the event register and returns the processor's reply.
// Optional reply timeout enabled by defining GAME_MBOX_TIMEOUT_EN.
module game_mailbox_ctrl
   import game_mbox_pkg::*;
#(
   parameter logic [4:0]  EVT_REG     = MBOX_EVT_REG,
   parameter logic [4:0]  REPLY_REG   = MBOX_REPLY_REG,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic              clock,
   input  logic              ctrl_reset,
   input  logic              cpu_we,
   input  logic [4:0]        cpu_wr_reg,
   input  logic [WORD_W-1:0] cpu_wr_data,
   input  logic              ev_valid,
   input  logic [WORD_W-1:0] ev_data,
   output logic              ev_ready,
   output logic              rf_we,
   output logic [4:0]        rf_wr_reg,
   output logic [WORD_W-1:0] rf_wr_data,
   output logic              reply_valid,
   output logic [WORD_W-1:0] reply_data,
   output logic              timeout,
   output logic              busy
);

   if (FIFO_DEPTH < 2 || TIMEOUT_CYC < 2) begin : g_bad_cfg
      $error("game_mailbox_ctrl: FIFO_DEPTH and TIMEOUT_CYC must both be at least 2");
   end

   mbox_state_e       state_q, state_d;
   logic [WORD_W-1:0] fifo_head;
   logic              fifo_full, fifo_empty;
   logic              pop, grant, reply_hit, timeout_hit;
   logic              reply_valid_q;
   logic [WORD_W-1:0] reply_data_q;

   mbox_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WORD_W)
   ) u_fifo (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .push       (ev_valid),
      .wdata      (ev_data),
      .pop        (pop),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   assign ev_ready = !fifo_full;

`ifdef GAME_MBOX_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q;
   logic             cnt_last;

   assign cnt_last = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
   // Outside WAIT the counter sits at zero, which also clears it on entry.
   assign cnt_d    = (state_q == WAIT) ? cnt_q + CNT_W'(1) : '0;

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_hit;
      end
   end

   assign timeout = timeout_q;
`else
   logic cnt_last;

   assign cnt_last = 1'b0;
   assign timeout  = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      grant       = 1'b0;
      reply_hit   = 1'b0;
      timeout_hit = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) state_d = INJECT;
         end
         INJECT: begin
            if (port_free(cpu_we, cpu_wr_reg)) begin
               grant   = 1'b1;
               pop     = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // A reply on the terminal-count cycle takes precedence over the timeout.
            if (cpu_we && (cpu_wr_reg == REPLY_REG)) begin
               reply_hit = 1'b1;
               state_d   = IDLE;
            end else if (cnt_last) begin
               timeout_hit = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rf_we      = cpu_we;
      rf_wr_reg  = cpu_wr_reg;
      rf_wr_data = cpu_wr_data;
      if (grant) begin
         rf_we      = 1'b1;
         rf_wr_reg  = EVT_REG;
         rf_wr_data = fifo_head;
      end
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         state_q       <= IDLE;
         reply_valid_q <= 1'b0;
         reply_data_q  <= '0;
      end else begin
         state_q       <= state_d;
         reply_valid_q <= reply_hit;
         if (reply_hit) reply_data_q <= cpu_wr_data;
      end
   end

   assign reply_valid = reply_valid_q;
   assign reply_data  = reply_data_q;
   assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_game_mailbox_ctrl.sv
// Directed self-checking bench for game_mailbox_ctrl (FIFO_DEPTH=4, TIMEOUT_CYC=8).
module tb_game_mailbox_ctrl;

   logic        clock = 1'b0;
   logic        ctrl_reset;
   logic        cpu_we;
   logic [4:0]  cpu_wr_reg;
   logic [31:0] cpu_wr_data;
   logic        ev_valid;
   logic [31:0] ev_data;
   logic        ev_ready;
   logic        rf_we;
   logic [4:0]  rf_wr_reg;
   logic [31:0] rf_wr_data;
   logic        reply_valid;
   logic [31:0] reply_data;
   logic        timeout;
   logic        busy;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   game_mailbox_ctrl #(
      .EVT_REG     (5'd20),
      .REPLY_REG   (5'd21),
      .FIFO_DEPTH  (4),
      .TIMEOUT_CYC (8)
   ) dut (
      .clock       (clock),
      .ctrl_reset  (ctrl_reset),
      .cpu_we      (cpu_we),
      .cpu_wr_reg  (cpu_wr_reg),
      .cpu_wr_data (cpu_wr_data),
      .ev_valid    (ev_valid),
      .ev_data     (ev_data),
      .ev_ready    (ev_ready),
      .rf_we       (rf_we),
      .rf_wr_reg   (rf_wr_reg),
      .rf_wr_data  (rf_wr_data),
      .reply_valid (reply_valid),
      .reply_data  (reply_data),
      .timeout     (timeout),
      .busy        (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   initial begin
      ctrl_reset  = 1'b1;
      cpu_we      = 1'b0;
      cpu_wr_reg  = 5'd0;
      cpu_wr_data = '0;
      ev_valid    = 1'b0;
      ev_data     = '0;

      // Reset values
      #2;
      chk("rst_reply_valid", 32'(reply_valid), 32'd0);
      chk("rst_reply_data", reply_data, 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ev_ready", 32'(ev_ready), 32'd1);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      cpu_we = 1'b1; cpu_wr_reg = 5'd9; cpu_wr_data = 32'h55;
      #1;
      chk("rst_pass_we", 32'(rf_we), 32'd1);
      chk("rst_pass_reg", 32'(rf_wr_reg), 32'd9);
      chk("rst_pass_data", rf_wr_data, 32'h55);
      cpu_we = 1'b0;
      tick();
      ctrl_reset = 1'b0;
      tick();

      // Idle port: event written two cycles after the push
      ev_valid = 1'b1; ev_data = 32'h7;
      tick();
      ev_valid = 1'b0;
      #1;
      chk("idle_busy", 32'(busy), 32'd1);
      chk("idle_no_early_we", 32'(rf_we), 32'd0);
      tick(); #1;
      chk("idle_inj_we", 32'(rf_we), 32'd1);
      chk("idle_inj_reg", 32'(rf_wr_reg), 32'd20);
      chk("idle_inj_data", rf_wr_data, 32'h7);
      tick(); #1;
      chk("wait_rf_we", 32'(rf_we), 32'd0);
      chk("wait_busy", 32'(busy), 32'd1);

      // Reply in WAIT
      cpu_we = 1'b1; cpu_wr_reg = 5'd21; cpu_wr_data = 32'hABCD;
      #1;
      chk("reply_pass_we", 32'(rf_we), 32'd1);
      chk("reply_pass_reg", 32'(rf_wr_reg), 32'd21);
      chk("reply_pass_data", rf_wr_data, 32'hABCD);
      chk("reply_not_yet", 32'(reply_valid), 32'd0);
      tick();
      cpu_we = 1'b0;
      #1;
      chk("reply_pulse", 32'(reply_valid), 32'd1);
      chk("reply_data", reply_data, 32'hABCD);
      chk("reply_idle_busy", 32'(busy), 32'd0);

      // r21 write outside WAIT: no pulse
      cpu_we = 1'b1; cpu_wr_reg = 5'd21; cpu_wr_data = 32'h1111;
      tick();
      cpu_we = 1'b0;
      #1;
      chk("stray_reply_pulse", 32'(reply_valid), 32'd0);
      chk("stray_reply_data", reply_data, 32'hABCD);

      // Contention: processor keeps the port busy for three INJECT cycles
      ev_valid = 1'b1; ev_data = 32'h42;
      cpu_we = 1'b1; cpu_wr_reg = 5'd5; cpu_wr_data = 32'h500;
      tick();
      ev_valid = 1'b0;
      #1;
      chk("cont_idle_pass_reg", 32'(rf_wr_reg), 32'd5);
      tick();
      for (int i = 0; i < 3; i++) begin
         cpu_wr_data = 32'h510 + 32'(i);
         #1;
         chk("cont_pass_we", 32'(rf_we), 32'd1);
         chk("cont_pass_reg", 32'(rf_wr_reg), 32'd5);
         chk("cont_pass_data", rf_wr_data, 32'h510 + 32'(i));
         tick();
      end
      // A write to r0 leaves the port free
      cpu_wr_reg = 5'd0; cpu_wr_data = 32'hDEAD;
      #1;
      chk("cont_inj_reg", 32'(rf_wr_reg), 32'd20);
      chk("cont_inj_data", rf_wr_data, 32'h42);
      tick();
      cpu_wr_reg = 5'd21; cpu_wr_data = 32'h77;
      tick();
      cpu_we = 1'b0;
      #1;
      chk("cont_reply_pulse", 32'(reply_valid), 32'd1);
      chk("cont_reply_data", reply_data, 32'h77);

      // Full FIFO with the port held busy
      cpu_we = 1'b1; cpu_wr_reg = 5'd5; cpu_wr_data = 32'h0;
      for (int k = 0; k < 4; k++) begin
         ev_valid = 1'b1; ev_data = 32'h100 + 32'(k);
         #1;
         chk("full_ready_before", 32'(ev_ready), 32'd1);
         tick();
      end
      ev_data = 32'h104;
      #1;
      chk("full_ready_low", 32'(ev_ready), 32'd0);
      tick(); #1;
      chk("full_held_off", 32'(ev_ready), 32'd0);
      cpu_we = 1'b0;
      #1;
      chk("full_inj_we", 32'(rf_we), 32'd1);
      chk("full_inj_data", rf_wr_data, 32'h100);
      chk("full_pop_no_free", 32'(ev_ready), 32'd0);
      tick(); #1;
      chk("full_ready_after_pop", 32'(ev_ready), 32'd1);
      tick();
      ev_valid = 1'b0;
      #1;
      chk("full_fifth_taken", 32'(ev_ready), 32'd0);

      // Drain two events through replies, leaving two queued in WAIT
      for (int j = 1; j <= 2; j++) begin
         cpu_we = 1'b1; cpu_wr_reg = 5'd21; cpu_wr_data = 32'(j);
         tick();
         cpu_we = 1'b0;
         #1;
         chk("drain_reply_pulse", 32'(reply_valid), 32'd1);
         chk("drain_reply_data", reply_data, 32'(j));
         tick(); #1;
         chk("drain_inj_reg", 32'(rf_wr_reg), 32'd20);
         chk("drain_inj_data", rf_wr_data, 32'h100 + 32'(j));
         tick();
      end
      #1;
      chk("pre_rst_busy", 32'(busy), 32'd1);
      chk("pre_rst_ready", 32'(ev_ready), 32'd1);

      // Reset mid-WAIT with two events queued
      ctrl_reset = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ready", 32'(ev_ready), 32'd1);
      chk("mid_rst_reply_data", reply_data, 32'd0);
      chk("mid_rst_reply_valid", 32'(reply_valid), 32'd0);
      chk("mid_rst_timeout", 32'(timeout), 32'd0);
      tick();
      ctrl_reset = 1'b0;
      for (int r = 0; r < 3; r++) begin
         tick(); #1;
         chk("post_rst_no_inj", 32'(rf_we), 32'd0);
         chk("post_rst_busy", 32'(busy), 32'd0);
      end

      // Timeout behaviour with a second event queued
      ev_valid = 1'b1; ev_data = 32'h900;
      tick();
      ev_data = 32'h901;
      tick();
      ev_valid = 1'b0;
      #1;
      chk("to_inj_we", 32'(rf_we), 32'd1);
      chk("to_inj_data", rf_wr_data, 32'h900);
      tick();
      for (int c = 0; c < 8; c++) begin
         #1;
         chk("to_wait_no_timeout", 32'(timeout), 32'd0);
         chk("to_wait_no_inj", 32'(rf_we), 32'd0);
         tick();
      end
`ifdef GAME_MBOX_TIMEOUT_EN
      #1;
      chk("to_pulse", 32'(timeout), 32'd1);
      chk("to_no_reply", 32'(reply_valid), 32'd0);
      tick(); #1;
      chk("to_pulse_end", 32'(timeout), 32'd0);
      chk("to_next_inj_we", 32'(rf_we), 32'd1);
      chk("to_next_inj_data", rf_wr_data, 32'h901);
      tick();
      cpu_we = 1'b1; cpu_wr_reg = 5'd21; cpu_wr_data = 32'h5;
      tick();
      cpu_we = 1'b0;
      #1;
      chk("to_final_reply", 32'(reply_valid), 32'd1);
`else
      #1;
      chk("noto_timeout_low", 32'(timeout), 32'd0);
      chk("noto_still_busy", 32'(busy), 32'd1);
      chk("noto_no_inj", 32'(rf_we), 32'd0);
      cpu_we = 1'b1; cpu_wr_reg = 5'd21; cpu_wr_data = 32'h5;
      tick();
      cpu_we = 1'b0;
      #1;
      chk("noto_reply", 32'(reply_valid), 32'd1);
      tick(); #1;
      chk("noto_next_inj_we", 32'(rf_we), 32'd1);
      chk("noto_next_inj_data", rf_wr_data, 32'h901);
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/game_mailbox_ctrl.md
# game_mailbox_ctrl

Sequences event traffic between the game logic and the processor through the register-file mailbox. Game-side events are buffered in a small FIFO and injected into the event register (r20) through the single register-file write port, which is shared with processor writeback. The block then waits for the processor's reply write to r21 and returns it to the game logic as a one-cycle pulse. It sits in front of the register-file write port; processor writeback always has priority.

## Interface
- EVT_REG, 20: register index receiving injected events
- REPLY_REG, 21: register index the processor writes replies to
- FIFO_DEPTH, 4: event FIFO entries, power of two, ≥2
- TIMEOUT_CYC, 1024: cycles to wait for a reply before abandoning; must be ≥2
- clock  in  1  system clock, rising edge
- ctrl_reset  in  1  asynchronous, active-high reset
- cpu_we  in  1  processor writeback enable
- cpu_wr_reg  in  5  processor writeback register index
- cpu_wr_data  in  32  processor writeback data
- ev_valid  in  1  game event offered
- ev_data  in  32  game event payload
- ev_ready  out  1  FIFO can accept an event
- rf_we  out  1  register-file write enable
- rf_wr_reg  out  5  register-file write index
- rf_wr_data  out  32  register-file write data
- reply_valid  out  1  one-cycle pulse: reply captured
- reply_data  out  32  captured reply, held until the next capture
- timeout  out  1  one-cycle pulse: reply wait abandoned
- busy  out  1  state ≠ IDLE or FIFO non-empty

## Operation
- The FIFO pushes when ev_valid && ev_ready. ev_ready = !full. It is registered-full based, so a pop does not free space in the same cycle.
- State IDLE: if the FIFO is non-empty, go to INJECT next cycle.
- State INJECT, port free (cpu_we == 0 or cpu_wr_reg == 0):
  - drive rf_we=1, rf_wr_reg=EVT_REG, rf_wr_data=FIFO head
  - pop the FIFO and go to WAIT
- State INJECT, port not free: pass the processor write through and stay in INJECT. The processor is never stalled and never dropped.
- In all non-grant cycles, rf_we, rf_wr_reg and rf_wr_data are a combinational copy of cpu_we, cpu_wr_reg and cpu_wr_data.
- State WAIT: a processor write with cpu_we && cpu_wr_reg == REPLY_REG is a reply. It captures cpu_wr_data into reply_data, pulses reply_valid next cycle, and returns to IDLE. The write still reaches the register file.
- Writes to REPLY_REG outside WAIT pass through and produce no pulse.
- A processor write to EVT_REG passes through unmodified. It may overwrite an injected event; software must not do this.
- Reset mid-operation returns the block to IDLE and empties the FIFO. A pending reply is lost.

## Timing
- Reset values:
  - registered outputs: reply_valid=0, reply_data=0, timeout=0, busy=0
  - ev_ready=1 (FIFO empty)
  - rf_* follow the cpu_* inputs
- An event pushed at edge N is in the FIFO at N+1, reaches INJECT at N+2, and is written at the end of the first free cycle from N+2 onward.
- Back-to-back events are serialized. The next injection happens only after the previous reply or timeout.
- reply_valid is asserted in the cycle after the REPLY_REG write, for exactly 1 cycle.
- Timeout:
  - the counter clears on entry to WAIT and increments each WAIT cycle
  - at TIMEOUT_CYC-1 with no reply that cycle: pulse timeout next cycle, go to IDLE
  - if the reply arrives in the same cycle as the terminal count, the reply wins

## Configuration
- GAME_MBOX_TIMEOUT_EN defined: the timeout counter and the timeout pulse exist as described.
- Not defined: the counter is removed, WAIT lasts until a reply, and timeout is tied to 0.

## Structure
- Shared package game_mbox_pkg holds:
  - state enum {IDLE, INJECT, WAIT}
  - mailbox register index constants (event 20, reply 21, shape 25, point 26)
  - the 32-bit word width constant
- The FIFO is a sub-module, mbox_fifo (parameterized depth and width; push, pop, head, full, empty).

## Test plan
- Idle port: push 0x0000_0007 with cpu_we=0 → rf_we=1, rf_wr_reg=20, rf_wr_data=7 two cycles later; busy=1.
- Contention: push an event while cpu_we=1 to r5 for 3 cycles → three r5 writes pass through, injection happens in the 4th cycle.
- Reply: in WAIT, processor writes 0xABCD to r21 → r21 written, reply_valid pulses once next cycle, reply_data=0xABCD, state returns to IDLE.
- Full FIFO: push 5 events with no replies, FIFO_DEPTH=4 → ev_ready drops after the 4th is buffered; the 5th is held off, and accepted only after a pop.
- Timeout (macro on, TIMEOUT_CYC=8): no reply → timeout pulses 8 cycles after entering WAIT; next event injected; reply_valid stays 0.
- Reset in WAIT with 2 events queued → outputs return to reset values, ev_ready=1, no injection follows.
